// File: rtl/asansor_pkg.sv
// Shared types and constants for the four-floor elevator controller.
// State codes are also exported as plain logic constants for legacy users.
package asansor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  typedef logic [1:0] floor_t;

  localparam int NUM_FLOORS = 4;
  localparam int TIMER_W    = 8;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MOVE = ST_MOVE;
  localparam logic [1:0] S_DOOR = ST_DOOR;

endpackage

// File: rtl/asansor_if.sv
// Call inputs and car status outputs of the elevator controller.
// master drives calls and observes status; slave is the controller side.
interface asansor_if;
  import asansor_pkg::*;

  logic [NUM_FLOORS-1:0] call_req;
  floor_t                cur_floor;
  logic                  moving;
  logic                  dir_up;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    output call_req,
    input  cur_floor, moving, dir_up, door_open, pending
  );

  modport slave (
    input  call_req,
    output cur_floor, moving, dir_up, door_open, pending
  );
endinterface

// File: rtl/asansor_hedef.sv
// SCAN target logic: which side of a floor has calls, and which way to head.
// Purely combinational; the caller chooses the reference floor.
module asansor_hedef
  import asansor_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pending,
  input  floor_t                cur_floor,
  input  logic                  dir_up,
  output logic                  call_above,
  output logic                  call_below,
  output logic                  next_dir
);

  // Keep the current direction while it still has work, otherwise reverse.
  always_comb begin
    call_above = 1'b0;
    call_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      call_above = call_above | (pending[i] & (i > int'(cur_floor)));
      call_below = call_below | (pending[i] & (i < int'(cur_floor)));
    end
    if (dir_up) begin
      next_dir = call_above | ~call_below;
    end else begin
      next_dir = call_above & ~call_below;
    end
  end

endmodule

// File: rtl/asansor_kontrol.sv
// Four-floor elevator controller: IDLE/MOVE/DOOR FSM, travel and door timers,
// and the latched-call register. All outputs come straight from flops.
module asansor_kontrol
  import asansor_pkg::*;
#(
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 4
) (
  input  logic     clk,
  input  logic     rst,
  asansor_if.slave bus
);

  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYC - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYC - 1);

  logic [1:0]            state_q, state_d;
  floor_t                cur_floor_q, cur_floor_d;
  logic                  dir_up_q, dir_up_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic                  moving_q, moving_d;
  logic                  door_open_q, door_open_d;

  floor_t                next_floor_s;
  floor_t                hedef_floor_s;
  logic                  call_above_s, call_below_s, next_dir_s, beyond_s;
  logic [NUM_FLOORS-1:0] call_in_s;

  // While moving, "beyond" is judged from the floor about to be reached.
  assign next_floor_s  = dir_up_q ? (cur_floor_q + 2'd1) : (cur_floor_q - 2'd1);
  assign hedef_floor_s = (state_q == S_MOVE) ? next_floor_s : cur_floor_q;
  assign beyond_s      = dir_up_q ? call_above_s : call_below_s;

  asansor_hedef u_hedef (
    .pending    (pending_q),
    .cur_floor  (hedef_floor_s),
    .dir_up     (dir_up_q),
    .call_above (call_above_s),
    .call_below (call_below_s),
    .next_dir   (next_dir_s)
  );

  // Next-state, timer and call-latch decisions.
  always_comb begin
    state_d     = state_q;
    cur_floor_d = cur_floor_q;
    dir_up_d    = dir_up_q;
    timer_d     = timer_q;
    call_in_s   = bus.call_req;
    if (state_q == S_DOOR) begin
      call_in_s[cur_floor_q] = 1'b0;
    end else begin
      call_in_s = bus.call_req;
    end
    pending_d = pending_q | call_in_s;

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (pending_q[cur_floor_q]) begin
          state_d                = S_DOOR;
          pending_d[cur_floor_q] = 1'b0;
        end else if (call_above_s || call_below_s) begin
          state_d  = S_MOVE;
          dir_up_d = next_dir_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MOVE: begin
        if (timer_q == TRAVEL_LAST) begin
          cur_floor_d = next_floor_s;
          timer_d     = '0;
          if (pending_q[next_floor_s]) begin
            state_d                 = S_DOOR;
            pending_d[next_floor_s] = 1'b0;
          end else if (beyond_s) begin
            state_d = S_MOVE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_DOOR: begin
        // A fresh call for this floor holds the door instead of being latched.
        if (bus.call_req[cur_floor_q]) begin
          timer_d = '0;
        end else if (timer_q == DOOR_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    moving_d    = (state_d == S_MOVE);
    door_open_d = (state_d == S_DOOR);
  end

  // State registers with synchronous reset; reset drops any calls present.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_floor_q <= 2'd0;
      dir_up_q    <= 1'b1;
      pending_q   <= '0;
      timer_q     <= '0;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_floor_q <= cur_floor_d;
      dir_up_q    <= dir_up_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
    end
  end

  assign bus.cur_floor = cur_floor_q;
  assign bus.moving    = moving_q;
  assign bus.dir_up    = dir_up_q;
  assign bus.door_open = door_open_q;
  assign bus.pending   = pending_q;

endmodule

// File: doc/asansor_kontrol.md
ASANSOR_KONTROL -- requirements
Module: asansor_kontrol

Interface
REQ-001 Parameter TRAVEL_CYC, default 8: clock cycles to travel one floor; legal range 2..255.
REQ-002 Parameter DOOR_CYC, default 4: clock cycles the door stays open; legal range 2..255.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 call_req  in  4  per-floor call, bit n = floor n, sampled every edge, level or pulse.
REQ-006 cur_floor  out  2  current car floor, 0..3.
REQ-007 moving  out  1  high while the state is MOVE.
REQ-008 dir_up  out  1  travel or preferred direction: 1 = up, 0 = down.
REQ-009 door_open  out  1  high while the state is DOOR.
REQ-010 pending  out  4  latched, unserved calls.

Function
REQ-011 The block SHALL implement three states: IDLE, MOVE and DOOR.
REQ-012 On each edge, pending SHALL become pending OR call_req, minus any bit cleared this edge; a call is never lost.
REQ-013 A call for cur_floor SHALL NOT be latched while in DOOR; instead it SHALL restart the door timer.
REQ-014 IDLE with pending[cur_floor]=1 SHALL go to DOOR and clear that bit on the same edge.
REQ-015 IDLE with other pending bits SHALL choose a direction by SCAN and go to MOVE on the next edge.
- SCAN rule: keep dir_up if any call exists in that direction; otherwise reverse.
- Timer loads 0 on entry to MOVE.
REQ-016 IDLE with pending=0 SHALL remain in IDLE and leave dir_up unchanged.
REQ-017 MOVE SHALL count TRAVEL_CYC cycles. On the last cycle, cur_floor SHALL step by ±1 per dir_up, and on that edge:
- if pending[new floor]=1, go to DOOR and clear the bit;
- else, if a call remains beyond the new floor in the current direction, stay in MOVE with the timer reset;
- else, go to IDLE.
REQ-018 cur_floor SHALL never step below 0 or above 3; dir_up SHALL never point past an end floor while in MOVE.
REQ-019 DOOR SHALL last DOOR_CYC cycles from entry or from the last restart, then go to IDLE.
REQ-020 A call arriving for the floor being approached before the step edge SHALL cause a stop at that floor.
REQ-021 Simultaneous calls above and below SHALL be served in the current dir_up direction first.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational path from call_req to any output.

Reset
REQ-023 With rst=1 at an edge, the block SHALL force:
- state IDLE, cur_floor 0, dir_up 1, moving 0, door_open 0;
- pending 0, timers 0.
REQ-024 Reset asserted mid-MOVE or mid-DOOR SHALL abandon the operation; calls present during reset SHALL be discarded.

Structure
REQ-025 A shared package asansor_pkg SHALL hold:
- the state enum (IDLE, MOVE, DOOR);
- the floor type (2 bits);
- the constant NUM_FLOORS=4;
- the timer width constant (8).
REQ-026 SCAN direction and stop decisions SHALL live in one combinational sub-module, asansor_hedef.
- Inputs: pending, cur_floor, dir_up.
- Outputs: call_above, call_below, next_dir.
REQ-027 The FSM, timers and pending register SHALL reside in asansor_kontrol.

Verification (TRAVEL_CYC=8, DOOR_CYC=4)
REQ-028 After reset, pulse call_req=1000 at edge E0 -> MOVE from E1; cur_floor reaches 1 at E9, 2 at E17, 3 at E25 with door_open=1 for 4 cycles; pending=0; then IDLE.
REQ-029 Idle at floor 0, call_req=0001 -> DOOR next edge, door_open 4 cycles, no movement; re-pulse 0001 during DOOR -> door open extended 4 cycles from that pulse.
REQ-030 Car moving up from 0 toward 3, call 0100 injected at cycle 5 -> stop at floor 2 before 3; then resume up to 3.
REQ-031 Car at 2 going up, pending 1001 -> serve 3 first, then reverse and serve 0; dir_up=0 while descending.
REQ-032 Assert rst during MOVE between floors 1 and 2 with pending 1000 -> next cycle cur_floor=0, pending=0, IDLE, all flags low except dir_up=1.
REQ-033 Random call stream for 10k cycles -> assertions hold: cur_floor in 0..3, moving and door_open never both high, every latched call served within 2*(3*TRAVEL_CYC+4*DOOR_CYC) cycles.
